// File: rtl/memshare_pgtbl_writer.sv
// Page-table writer: turns a stream of config beats into regFile writes of {isEnd, payload}
// at address {page, flag}, counting one pattern per closing beat until every flag pattern is loaded.
module memshare_pgtbl_writer #(
  parameter int MODE_BITWIDTH       = 2,
  parameter int SHARED_BANK_NUM     = 5,
  parameter int DATA_BITWIDTH       = 7,
  parameter int TYPE0_ADDR_BITWIDTH = MODE_BITWIDTH + SHARED_BANK_NUM
) (
  input  logic                                   sys_clk,
  input  logic                                   rstn,
  input  logic                                   load_start_i,
  input  logic                                   cfg_valid_i,
  output logic                                   cfg_ready_o,
  input  logic [SHARED_BANK_NUM-1:0]             cfg_flag_i,
  input  logic [DATA_BITWIDTH-1:0]               cfg_data_i,
  input  logic                                   cfg_last_i,
  output logic                                   we_o,
  output logic [TYPE0_ADDR_BITWIDTH-1:0]         waddr_o,
  output logic [MODE_BITWIDTH+DATA_BITWIDTH-1:0] wdata_o,
  output logic                                   done_o,
  output logic                                   err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [MODE_BITWIDTH-1:0]   PAGE_MAX = '1;
  localparam logic [SHARED_BANK_NUM:0]   PAT_FULL = {1'b1, {SHARED_BANK_NUM{1'b0}}};

  logic [1:0]                               state_q, state_d;
  logic [MODE_BITWIDTH-1:0]                 page_q, page_d;
  logic [SHARED_BANK_NUM:0]                 pat_q, pat_d;
  logic [SHARED_BANK_NUM-1:0]               flag_q, flag_d;
  logic                                     err_q, err_d;
  logic                                     we_q, we_d;
  logic [TYPE0_ADDR_BITWIDTH-1:0]           waddr_q, waddr_d;
  logic [MODE_BITWIDTH+DATA_BITWIDTH-1:0]   wdata_q, wdata_d;

  logic load_busy;
  logic accept;
  logic closing;
  logic flag_mismatch;

  // Once the last pattern is counted, intake stops while the FSM steps into DONE a cycle later.
  assign load_busy     = (state_q == S_LOAD) && (pat_q != PAT_FULL);
  assign cfg_ready_o   = load_busy && !load_start_i;
  assign accept        = cfg_valid_i && cfg_ready_o;
  assign closing       = cfg_last_i || (page_q == PAGE_MAX);
  assign flag_mismatch = (page_q != '0) && (cfg_flag_i != flag_q);

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    pat_d   = pat_q;
    flag_d  = flag_q;
    err_d   = err_q;
    we_d    = accept;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (load_start_i) begin
      state_d = S_LOAD;
      page_d  = '0;
      pat_d   = '0;
      flag_d  = '0;
      err_d   = 1'b0;
    end else if ((state_q == S_LOAD) && (pat_q == PAT_FULL)) begin
      state_d = S_DONE;
    end else if (accept) begin
      waddr_d = {page_q, cfg_flag_i};
      wdata_d = {{MODE_BITWIDTH{closing}}, cfg_data_i};
      if (page_q == '0) begin
        flag_d = cfg_flag_i;
      end
      // A forced close (page space exhausted without last) is a protocol error too.
      if ((closing && !cfg_last_i) || flag_mismatch) begin
        err_d = 1'b1;
      end
      if (closing) begin
        page_d = '0;
        pat_d  = pat_q + 1'b1;
      end else begin
        page_d = page_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      page_q  <= '0;
      pat_q   <= '0;
      flag_q  <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      pat_q   <= pat_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign we_o    = we_q;
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;
  assign done_o  = (state_q == S_DONE);
  assign err_o   = err_q;

endmodule
